// File: rtl/router_pkg.sv
// Shared types and defaults for the packet router control FSM.
// Holds the state enum, default geometry and the address-to-one-hot helper.
package router_pkg;

    localparam int unsigned NUM_PORTS_DEF = 3;
    localparam int unsigned ADDR_W_DEF    = 2;
    localparam int unsigned MAX_PORTS     = 8;

    typedef enum logic [3:0] {
        StDecodeAddress,
        StWaitTillEmpty,
        StLoadFirstData,
        StLoadData,
        StLoadParity,
        StFifoFullState,
        StLoadAfterFull,
        StCheckParityError,
        StDropPacket
    } router_state_e;

    // Addresses beyond the widest supported router map to all-zeros.
    function automatic logic [MAX_PORTS-1:0] addr_onehot(input int unsigned addr);
        logic [MAX_PORTS-1:0] oh;
        oh = '0;
        if (addr < MAX_PORTS) begin
            oh[addr] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/router_fsm_param.sv
// Router control FSM: steers a packet into one of NUM_PORTS FIFOs, handles full/parity
// sequencing, discards packets with out-of-range addresses and counts them.
module router_fsm_param
    import router_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [ADDR_W-1:0]     data_in,
    input  logic                  fifo_full,
    input  logic [NUM_PORTS-1:0]  fifo_empty,
    input  logic [NUM_PORTS-1:0]  soft_reset,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic                  write_enb_reg,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  rst_int_reg,
    output logic                  busy,
    output logic [NUM_PORTS-1:0]  dest_sel,
    output logic                  drop_state,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    router_state_e         state_q, state_d;
    logic [NUM_PORTS-1:0]  dest_sel_q, dest_sel_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [NUM_PORTS-1:0]  addr_oh;
    logic                  addr_valid;
    logic                  addr_empty;
    logic                  dest_empty;
    logic                  soft_hit;

    // An out-of-range address yields an all-zero one-hot, which doubles as the validity test.
    always_comb begin
        addr_oh    = NUM_PORTS'(addr_onehot(32'(data_in)));
        addr_valid = |addr_oh;
        addr_empty = |(addr_oh & fifo_empty);
        dest_empty = |(dest_sel_q & fifo_empty);
        soft_hit   = |(dest_sel_q & soft_reset);
    end

    always_comb begin
        state_d    = state_q;
        dest_sel_d = dest_sel_q;
        drop_cnt_d = drop_cnt_q;

        unique case (state_q)
            StDecodeAddress: begin
                if (pkt_valid) begin
                    if (addr_valid) begin
                        dest_sel_d = addr_oh;
                        state_d    = addr_empty ? StLoadFirstData : StWaitTillEmpty;
                    end else begin
                        state_d = StDropPacket;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                        end
                    end
                end
            end
            StWaitTillEmpty: begin
                if (dest_empty) begin
                    state_d = StLoadFirstData;
                end
            end
            StLoadFirstData: begin
                state_d = StLoadData;
            end
            StLoadData: begin
                if (fifo_full) begin
                    state_d = StFifoFullState;
                end else if (!pkt_valid) begin
                    state_d = StLoadParity;
                end
            end
            StLoadParity: begin
                state_d = StCheckParityError;
            end
            StFifoFullState: begin
                if (!fifo_full) begin
                    state_d = StLoadAfterFull;
                end
            end
            StLoadAfterFull: begin
                if (parity_done) begin
                    state_d = StDecodeAddress;
                end else if (low_pkt_valid) begin
                    state_d = StLoadParity;
                end else begin
                    state_d = StLoadData;
                end
            end
            StCheckParityError: begin
                state_d = fifo_full ? StFifoFullState : StDecodeAddress;
            end
            StDropPacket: begin
                if (!pkt_valid) begin
                    state_d = StDecodeAddress;
                end
            end
            default: begin
                state_d = StDecodeAddress;
            end
        endcase

        // A read timeout on the selected FIFO abandons whatever packet is in flight.
        if (soft_hit && (state_q != StDecodeAddress) && (state_q != StDropPacket)) begin
            state_d = StDecodeAddress;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StDecodeAddress;
            dest_sel_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dest_sel_q <= dest_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        detect_add    = (state_q == StDecodeAddress);
        lfd_state     = (state_q == StLoadFirstData);
        ld_state      = (state_q == StLoadData);
        laf_state     = (state_q == StLoadAfterFull);
        full_state    = (state_q == StFifoFullState);
        rst_int_reg   = (state_q == StCheckParityError);
        drop_state    = (state_q == StDropPacket);
        write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                        (state_q == StLoadAfterFull);
        busy          = !((state_q == StDecodeAddress) || (state_q == StLoadData) ||
                          (state_q == StDropPacket));
        dest_sel      = dest_sel_q;
        drop_cnt      = drop_cnt_q;
    end

endmodule

// File: tb/tb_router_fsm_param.sv
// Self-checking bench for router_fsm_param: directed packet scenarios plus randomized
// traffic, all compared each cycle against a behavioural model of the routing rules.
module tb_router_fsm_param;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int DW = 8;

    // Model phases, named after the packet life cycle.
    localparam int M_DEC  = 0;
    localparam int M_WAIT = 1;
    localparam int M_LFD  = 2;
    localparam int M_LD   = 3;
    localparam int M_LP   = 4;
    localparam int M_FULL = 5;
    localparam int M_LAF  = 6;
    localparam int M_CPE  = 7;
    localparam int M_DROP = 8;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [AW-1:0] data_in;
    logic          fifo_full;
    logic [NP-1:0] fifo_empty;
    logic [NP-1:0] soft_reset;
    logic          parity_done;
    logic          low_pkt_valid;
    logic          write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic          full_state, rst_int_reg, busy, drop_state;
    logic [NP-1:0] dest_sel;
    logic [DW-1:0] drop_cnt;

    int            n_checks = 0;
    int            n_pass   = 0;

    int            m_state;
    logic [NP-1:0] m_dest;
    int            m_drop;

    always #5 clock = ~clock;

    router_fsm_param #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DROP_CNT_W(DW)
    ) u_dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .soft_reset   (soft_reset),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .busy         (busy),
        .dest_sel     (dest_sel),
        .drop_state   (drop_state),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // {write_enb, detect_add, lfd, ld, laf, full, rst_int, busy, drop}
    function automatic logic [8:0] m_outs(input int s);
        logic we, bz;
        we = (s == M_LD) || (s == M_LP) || (s == M_LAF);
        bz = !((s == M_DEC) || (s == M_LD) || (s == M_DROP));
        return {we, s == M_DEC, s == M_LFD, s == M_LD, s == M_LAF, s == M_FULL,
                s == M_CPE, bz, s == M_DROP};
    endfunction

    task automatic model_reset();
        m_state = M_DEC;
        m_dest  = '0;
        m_drop  = 0;
    endtask

    task automatic model_step();
        int  nxt;
        int  a;
        bit  timeout;
        nxt     = m_state;
        a       = int'(data_in);
        timeout = ((soft_reset & m_dest) != '0) && (m_state != M_DEC) && (m_state != M_DROP);
        case (m_state)
            M_DEC: if (pkt_valid) begin
                if (a < NP) begin
                    nxt       = fifo_empty[a] ? M_LFD : M_WAIT;
                    m_dest    = '0;
                    m_dest[a] = 1'b1;
                end else begin
                    nxt = M_DROP;
                    if (m_drop < 255) m_drop++;
                end
            end
            M_WAIT:  if ((fifo_empty & m_dest) != '0) nxt = M_LFD;
            M_LFD:   nxt = M_LD;
            M_LD:    if (fifo_full) nxt = M_FULL; else if (!pkt_valid) nxt = M_LP;
            M_LP:    nxt = M_CPE;
            M_FULL:  if (!fifo_full) nxt = M_LAF;
            M_LAF:   nxt = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
            M_CPE:   nxt = fifo_full ? M_FULL : M_DEC;
            M_DROP:  if (!pkt_valid) nxt = M_DEC;
            default: nxt = M_DEC;
        endcase
        if (timeout) nxt = M_DEC;
        m_state = nxt;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "/outs"}, {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                               full_state, rst_int_reg, busy, drop_state}, m_outs(m_state));
        check({tag, "/dest_sel"}, dest_sel, m_dest);
        check({tag, "/drop_cnt"}, drop_cnt, m_drop);
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        #1;
        model_step();
        compare_all(tag);
    endtask

    // Asynchronous reset: outputs must change without waiting for a clock edge.
    task automatic async_reset(input string tag);
        resetn = 1'b0;
        #2;
        model_reset();
        compare_all(tag);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic idle_inputs();
        pkt_valid     = 1'b0;
        data_in       = '0;
        fifo_full     = 1'b0;
        fifo_empty    = '0;
        soft_reset    = '0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        async_reset("reset");
        check("reset/detect_add", detect_add, 1'b1);

        // Clean packet to port 2.
        pkt_valid  = 1'b1;
        data_in    = 2'd2;
        fifo_empty = 3'b100;
        for (int i = 0; i < 4; i++) tick("pkt");
        pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick("pkt");
        check("pkt/dest", dest_sel, 3'b100);
        check("pkt/back_to_decode", detect_add, 1'b1);

        // Destination busy for five cycles.
        pkt_valid  = 1'b1;
        data_in    = 2'd1;
        fifo_empty = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick("wait");
            check("wait/busy", busy, 1'b1);
        end
        fifo_empty = 3'b010;
        tick("wait");
        check("wait/lfd", lfd_state, 1'b1);
        tick("wait");

        // FIFO full for two cycles, then resume with low_pkt_valid.
        fifo_full = 1'b1;
        tick("full");
        tick("full");
        check("full/full_state", full_state, 1'b1);
        fifo_full     = 1'b0;
        low_pkt_valid = 1'b1;
        tick("full");
        check("full/laf", laf_state, 1'b1);
        tick("full");
        pkt_valid     = 1'b0;
        low_pkt_valid = 1'b0;
        tick("full");
        tick("full");

        // Invalid-address drops and counter saturation.
        async_reset("drop_rst");
        pkt_valid = 1'b1;
        data_in   = 2'd3;
        for (int i = 0; i < 4; i++) tick("drop");
        pkt_valid = 1'b0;
        tick("drop");
        check("drop/cnt1", drop_cnt, 8'd1);
        for (int i = 0; i < 256; i++) begin
            pkt_valid = 1'b1;
            tick("drop_sat");
            pkt_valid = 1'b0;
            tick("drop_sat");
        end
        check("drop/saturated", drop_cnt, 8'd255);

        // Soft reset only acts on the selected port.
        pkt_valid  = 1'b1;
        data_in    = 2'd0;
        fifo_empty = 3'b001;
        tick("soft");
        tick("soft");
        fifo_full = 1'b1;
        tick("soft");
        soft_reset = 3'b010;
        tick("soft");
        check("soft/unselected", full_state, 1'b1);
        soft_reset = 3'b001;
        tick("soft");
        check("soft/selected", detect_add, 1'b1);
        idle_inputs();
        tick("soft");

        // Reset in the middle of a packet.
        pkt_valid  = 1'b1;
        data_in    = 2'd2;
        fifo_empty = 3'b100;
        tick("midrst");
        tick("midrst");
        check("midrst/in_ld", ld_state, 1'b1);
        async_reset("midrst");
        check("midrst/dest", dest_sel, 3'b000);
        check("midrst/drop", drop_cnt, 8'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = AW'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            fifo_empty    = NP'($urandom);
            soft_reset    = ($urandom_range(0, 15) == 0) ? NP'($urandom) : '0;
            parity_done   = ($urandom_range(0, 2) == 0);
            low_pkt_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rand_rst");
            end else begin
                tick("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
